decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Registered, parametrised successor of the combinational instruction decoder, sitting between fetch and rename/dispatch.
- Decodes one RV32I instruction per cycle, with optional M-extension support.
- Adds SRA/SLTU decode and illegal-instruction flagging.
- Buffers decoded packets in a DEPTH-entry skid FIFO with valid/ready handshakes on both sides and a pipeline flush.

Parameters:
XLEN, 32, instruction and immediate width (only 32 is legal).
PC_W, 9, width of the PC carried with each instruction.
DEPTH, 2, output FIFO entries (must be ≥2, power of two).
ENABLE_M, 0, 1 = decode RV32M as FUtype 2'b11; 0 = RV32M flagged illegal.

Ports:
clk  in  1  clock; one clock, all state on rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  drop all buffered and incoming instructions
instruction  in  XLEN  raw instruction
i_pc  in  PC_W  PC of instruction
i_valid  in  1  upstream valid
o_ready  out  1  stage can accept (to fetch)
o_valid  out  1  decoded packet valid (to dispatch)
i_ready  in  1  downstream ready
o_pc  out  PC_W  PC of head packet
rs1, rs2, rd  out  5 each  register indices (0 when unused)
ALUsrc, Branch, Memread, Memwrite, Regwrite  out  1 each  control bits
immediate  out  XLEN  sign-extended immediate
ALUOp  out  4  operation code
FUtype  out  2  00 ALU, 01 branch, 10 LSU, 11 MUL/DIV
illegal  out  1  unrecognised or disabled encoding

Behaviour:
- Reset: FIFO empty, count=0, o_valid=0, all packet outputs 0, o_ready=1 in the first cycle after reset.
- Accept: fire_in = i_valid && o_ready. o_ready = (count != DEPTH), driven from registered state only, with no combinational path from i_ready.
- Dequeue: fire_out = o_valid && i_ready. o_valid = (count != 0). Outputs always show the FIFO head and hold stable while o_valid && !i_ready.
- Latency: an instruction accepted at edge t is visible on o_valid after edge t (one cycle).
- NOP squash: exactly 0x00000013 is accepted (consumes the handshake) but never enqueued.
- Simultaneous fire_in and fire_out: count unchanged, order preserved. Empty FIFO with fire_in: head becomes visible next cycle (no bypass).
- Full FIFO: o_ready=0. A dequeue that cycle raises o_ready the next cycle.
- Pointers wrap modulo DEPTH.
- flush (priority over everything except reset): count←0 and pointers←0 at the edge, o_valid=0 the next cycle, and any fire_in that cycle is discarded.
- Reset mid-operation: same as flush, plus outputs cleared to 0.
- Immediate generation:
  - I-type (opcodes 0000011, 0010011, 1100111): {20×inst[31], inst[31:20]}
  - S-type (0100011): {inst[31:25], inst[11:7]}, sign-extended
  - B-type (1100011): {inst[31], inst[7], inst[30:25], inst[11:8], 0}, sign-extended
  - U-type (0110111, 0010111): {inst[31:12], 12'b0}
  - J-type (1101111): {inst[31], inst[19:12], inst[20], inst[30:21], 0}, sign-extended
  - Otherwise 0.
- ALUOp codes: ADD 0000, SUB 0001, SLL 0010, SLT 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, LUI 1000, AUIPC 1001, SRA 1010, SLTU 1011.
- R-type (0110011):
  - funct7 0000000: add/sll/slt/sltu/xor/srl/or/and.
  - funct7 0100000: funct3 000 → SUB, funct3 101 → SRA; other funct3 illegal.
  - funct7 0000001: if ENABLE_M, FUtype=11 and ALUOp={0,funct3}; otherwise illegal.
  - Any other funct7: illegal.
- I-type ALU (0010011): ALUsrc=1.
  - SLTIU → SLTU.
  - SLLI requires funct7=0000000.
  - funct3 101: funct7 0000000 → SRLI, 0100000 → SRAI; otherwise illegal.
- Load (0000011) / store (0100011): FUtype=10, ALUsrc=1, ALUOp={0,funct3}.
  - Load funct3 ∈ {000,001,010,100,101}; store funct3 ∈ {000,001,010}; else illegal.
- Branch (1100011): FUtype=01, Branch=1, ALUOp={0,funct3}; funct3 010/011 illegal.
- LUI / AUIPC: FUtype=00, ALUsrc=1, Regwrite=1, rd set.
- JAL / JALR: FUtype=01, Branch=1, Regwrite=1, ALUsrc=1. JALR requires funct3=000, else illegal.
- Illegal packets are still enqueued (so the ROB can raise an exception) with illegal=1, Regwrite=Memread=Memwrite=Branch=0, and rs1=rs2=rd=0.

Test Plan:
- Reset, then 0x002081B3 (add x3,x1,x2) with i_pc=4 → next cycle o_valid=1, rs1=1, rs2=2, rd=3, ALUOp=0000, FUtype=00, Regwrite=1, o_pc=4, illegal=0.
- 0x402081B3 → ALUOp=0001. 0x4020D1B3 → ALUOp=1010. 0x022081B3 → FUtype=11 with ENABLE_M=1; illegal=1, Regwrite=0 with ENABLE_M=0.
- 0xFE208EE3 (beq x1,x2,-4) → immediate=0xFFFFFFFC, Branch=1, FUtype=01, ALUOp=0000, rd=0.
- Sequence add, 0x00000013, sub → exactly two o_valid packets, in order (add, sub).
- i_ready=0 while presenting 3 instructions → o_ready low after 2 accepted, head outputs stable. Then i_ready=1 → 3 packets drain in order, o_ready re-asserts one cycle after the first dequeue.
- Full FIFO plus a valid input, assert flush for 1 cycle → next cycle o_valid=0, o_ready=1, and the flushed input never appears.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I(+M) decoder feeding a DEPTH-entry packet FIFO
// with valid/ready on both sides and a pipeline flush.
module decode_stage #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned PC_W     = 9,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned ENABLE_M = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic [XLEN-1:0] instruction,
  input  logic [PC_W-1:0] i_pc,
  input  logic            i_valid,
  output logic            o_ready,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [PC_W-1:0] o_pc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            ALUsrc,
  output logic            Branch,
  output logic            Memread,
  output logic            Memwrite,
  output logic            Regwrite,
  output logic [XLEN-1:0] immediate,
  output logic [3:0]      ALUOp,
  output logic [1:0]      FUtype,
  output logic            illegal
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_R      = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_SLL   = 4'b0010,
    ALU_SLT   = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_OR    = 4'b0110,
    ALU_AND   = 4'b0111,
    ALU_LUI   = 4'b1000,
    ALU_AUIPC = 4'b1001,
    ALU_SRA   = 4'b1010,
    ALU_SLTU  = 4'b1011
  } aluop_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            alusrc;
    logic            branch;
    logic            memread;
    logic            memwrite;
    logic            regwrite;
    logic [XLEN-1:0] imm;
    logic [3:0]      aluop;
    logic [1:0]      futype;
    logic            illegal;
  } pkt_t;

  // Base ALU operation selected by funct3 (funct7 variants handled by caller)
  function automatic aluop_e alu_f3(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  opcode_e     opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [XLEN-1:0] imm_dec;
  pkt_t        dec;
  logic        bad;

  assign opc = opcode_e'(instruction[6:0]);
  assign f3  = instruction[14:12];
  assign f7  = instruction[31:25];

  // Immediate generation by instruction format
  always_comb begin
    imm_dec = '0;
    case (opc)
      OP_LOAD, OP_IMM, OP_JALR:
        imm_dec = {{20{instruction[31]}}, instruction[31:20]};
      OP_STORE:
        imm_dec = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      OP_BRANCH:
        imm_dec = {{19{instruction[31]}}, instruction[31], instruction[7],
                   instruction[30:25], instruction[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm_dec = {instruction[31:12], 12'b0};
      OP_JAL:
        imm_dec = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                   instruction[20], instruction[30:21], 1'b0};
      default: imm_dec = '0;
    endcase
  end

  // Control decode; illegal encodings keep the PC and flag but drop side effects
  always_comb begin
    dec     = '0;
    dec.pc  = i_pc;
    dec.imm = imm_dec;
    bad     = 1'b0;
    case (opc)
      OP_R: begin
        dec.rs1      = instruction[19:15];
        dec.rs2      = instruction[24:20];
        dec.rd       = instruction[11:7];
        dec.regwrite = 1'b1;
        case (f7)
          7'b0000000: dec.aluop = alu_f3(f3);
          7'b0100000: begin
            if (f3 == 3'b000)      dec.aluop = ALU_SUB;
            else if (f3 == 3'b101) dec.aluop = ALU_SRA;
            else                   bad = 1'b1;
          end
          7'b0000001: begin
            if (ENABLE_M != 0) begin
              dec.futype = 2'b11;
              dec.aluop  = {1'b0, f3};
            end else begin
              bad = 1'b1;
            end
          end
          default: bad = 1'b1;
        endcase
      end
      OP_IMM: begin
        dec.rs1      = instruction[19:15];
        dec.rd       = instruction[11:7];
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        case (f3)
          3'b001: begin
            dec.aluop = ALU_SLL;
            bad       = (f7 != 7'b0000000);
          end
          3'b101: begin
            if (f7 == 7'b0000000)      dec.aluop = ALU_SRL;
            else if (f7 == 7'b0100000) dec.aluop = ALU_SRA;
            else                       bad = 1'b1;
          end
          default: dec.aluop = alu_f3(f3);
        endcase
      end
      OP_LOAD: begin
        dec.rs1      = instruction[19:15];
        dec.rd       = instruction[11:7];
        dec.futype   = 2'b10;
        dec.alusrc   = 1'b1;
        dec.memread  = 1'b1;
        dec.regwrite = 1'b1;
        dec.aluop    = {1'b0, f3};
        bad          = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OP_STORE: begin
        dec.rs1      = instruction[19:15];
        dec.rs2      = instruction[24:20];
        dec.futype   = 2'b10;
        dec.alusrc   = 1'b1;
        dec.memwrite = 1'b1;
        dec.aluop    = {1'b0, f3};
        bad          = f3[2] || (f3 == 3'b011);
      end
      OP_BRANCH: begin
        dec.rs1    = instruction[19:15];
        dec.rs2    = instruction[24:20];
        dec.futype = 2'b01;
        dec.branch = 1'b1;
        dec.aluop  = {1'b0, f3};
        bad        = (f3[2:1] == 2'b01);
      end
      OP_LUI, OP_AUIPC: begin
        dec.rd       = instruction[11:7];
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.aluop    = (opc == OP_LUI) ? ALU_LUI : ALU_AUIPC;
      end
      OP_JAL, OP_JALR: begin
        dec.rd       = instruction[11:7];
        dec.futype   = 2'b01;
        dec.branch   = 1'b1;
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.aluop    = ALU_ADD;
        if (opc == OP_JALR) begin
          dec.rs1 = instruction[19:15];
          bad     = (f3 != 3'b000);
        end
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      dec.illegal  = 1'b1;
      dec.regwrite = 1'b0;
      dec.memread  = 1'b0;
      dec.memwrite = 1'b0;
      dec.branch   = 1'b0;
      dec.rs1      = '0;
      dec.rs2      = '0;
      dec.rd       = '0;
    end
  end

  pkt_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          fire_in, fire_out, push;
  pkt_t          head;

  assign o_ready  = (count_q != CW'(DEPTH));
  assign o_valid  = (count_q != '0);
  assign fire_in  = i_valid && o_ready;
  assign fire_out = o_valid && i_ready;
  // A NOP consumes the handshake but is never stored
  assign push     = fire_in && (instruction != NOP);

  // FIFO storage, pointers and occupancy; flush drops everything held or arriving
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= dec;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (fire_out) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, fire_out})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign o_pc      = head.pc;
  assign rs1       = head.rs1;
  assign rs2       = head.rs2;
  assign rd        = head.rd;
  assign ALUsrc    = head.alusrc;
  assign Branch    = head.branch;
  assign Memread   = head.memread;
  assign Memwrite  = head.memwrite;
  assign Regwrite  = head.regwrite;
  assign immediate = head.imm;
  assign ALUOp     = head.aluop;
  assign FUtype    = head.futype;
  assign illegal   = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench driving two decode_stage instances
// (ENABLE_M=0 and ENABLE_M=1) with identical directed vectors.
module tb_decode_stage;

  typedef struct packed {
    logic [8:0]  pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        alusrc;
    logic        branch;
    logic        memread;
    logic        memwrite;
    logic        regwrite;
    logic [31:0] imm;
    logic [3:0]  aluop;
    logic [1:0]  futype;
    logic        illegal;
  } pkt_t;

  logic        clk = 1'b0;
  logic        reset, flush, i_valid, i_ready;
  logic [31:0] instruction;
  logic [8:0]  i_pc;

  logic        o_ready_a  [2];
  logic        o_valid_a  [2];
  logic [8:0]  o_pc_a     [2];
  logic [4:0]  rs1_a      [2];
  logic [4:0]  rs2_a      [2];
  logic [4:0]  rd_a       [2];
  logic        alusrc_a   [2];
  logic        branch_a   [2];
  logic        memread_a  [2];
  logic        memwrite_a [2];
  logic        regwrite_a [2];
  logic [31:0] imm_a      [2];
  logic [3:0]  aluop_a    [2];
  logic [1:0]  futype_a   [2];
  logic        illegal_a  [2];

  pkt_t q0[$];
  pkt_t q1[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .PC_W(9), .DEPTH(2), .ENABLE_M(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .instruction(instruction),
    .i_pc(i_pc), .i_valid(i_valid), .o_ready(o_ready_a[0]), .o_valid(o_valid_a[0]),
    .i_ready(i_ready), .o_pc(o_pc_a[0]), .rs1(rs1_a[0]), .rs2(rs2_a[0]), .rd(rd_a[0]),
    .ALUsrc(alusrc_a[0]), .Branch(branch_a[0]), .Memread(memread_a[0]),
    .Memwrite(memwrite_a[0]), .Regwrite(regwrite_a[0]), .immediate(imm_a[0]),
    .ALUOp(aluop_a[0]), .FUtype(futype_a[0]), .illegal(illegal_a[0]));

  decode_stage #(.XLEN(32), .PC_W(9), .DEPTH(2), .ENABLE_M(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .instruction(instruction),
    .i_pc(i_pc), .i_valid(i_valid), .o_ready(o_ready_a[1]), .o_valid(o_valid_a[1]),
    .i_ready(i_ready), .o_pc(o_pc_a[1]), .rs1(rs1_a[1]), .rs2(rs2_a[1]), .rd(rd_a[1]),
    .ALUsrc(alusrc_a[1]), .Branch(branch_a[1]), .Memread(memread_a[1]),
    .Memwrite(memwrite_a[1]), .Regwrite(regwrite_a[1]), .immediate(imm_a[1]),
    .ALUOp(aluop_a[1]), .FUtype(futype_a[1]), .illegal(illegal_a[1]));

  function automatic pkt_t mk(input logic [8:0] pc, input logic [4:0] s1, input logic [4:0] s2,
                              input logic [4:0] d, input logic as, input logic br,
                              input logic mr, input logic mw, input logic rw,
                              input logic [31:0] imm, input logic [3:0] op,
                              input logic [1:0] fu, input logic ill);
    pkt_t p;
    p = '{pc, s1, s2, d, as, br, mr, mw, rw, imm, op, fu, ill};
    return p;
  endfunction

  function automatic pkt_t act(input int k);
    return '{o_pc_a[k], rs1_a[k], rs2_a[k], rd_a[k], alusrc_a[k], branch_a[k],
             memread_a[k], memwrite_a[k], regwrite_a[k], imm_a[k], aluop_a[k],
             futype_a[k], illegal_a[k]};
  endfunction

  // For illegal packets only the side-effect fields and identity are defined
  task automatic cmp(input string name, input pkt_t a, input pkt_t e);
    pkt_t m;
    m = '1;
    if (e.illegal) begin
      m.alusrc = 1'b0;
      m.imm    = '0;
      m.aluop  = '0;
      m.futype = '0;
    end
    checks++;
    if ((a & m) !== (e & m)) begin
      errors++;
      $display("FAIL %s pc=%h got %h want %h", name, e.pc, a & m, e & m);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Monitor: every dequeue handshake pops and compares one expected packet
  always @(posedge clk) begin
    if (!reset) begin
      if (o_valid_a[0] && i_ready) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pkt0 got pc %h want none", o_pc_a[0]);
        end else cmp("pkt_m0", act(0), q0.pop_front());
      end
      if (o_valid_a[1] && i_ready) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pkt1 got pc %h want none", o_pc_a[1]);
        end else cmp("pkt_m1", act(1), q1.pop_front());
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic [31:0] ins, input logic [8:0] pc,
                      input pkt_t e0, input pkt_t e1, input bit squash);
    int n;
    instruction = ins;
    i_pc        = pc;
    i_valid     = 1'b1;
    n = 0;
    while (!o_ready_a[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL send_timeout got o_ready 0 want 1 pc=%h", pc);
    end
    if (!squash) begin
      q0.push_back(e0);
      q1.push_back(e1);
    end
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic send1(input logic [31:0] ins, input logic [8:0] pc, input pkt_t e);
    send(ins, pc, e, e, 1'b0);
  endtask

  task automatic drain_check(input string name);
    repeat (6) @(negedge clk);
    chk(name, q0.size() + q1.size(), 0);
  endtask

  initial begin
    pkt_t e;
    reset = 1'b1; flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    instruction = '0; i_pc = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_o_ready", o_ready_a[0], 1);
    chk("rst_o_valid", o_valid_a[0], 0);
    chk("rst_outputs", act(0), '0);

    // add x3,x1,x2 then latency check
    send1(32'h002081B3, 9'd4, mk(9'd4, 1, 2, 3, 0, 0, 0, 0, 1, 0, 4'h0, 2'b00, 0));
    chk("latency_valid", o_valid_a[0], 1);
    chk("latency_pc", o_pc_a[0], 4);
    // NOP squashed between add and sub
    send(32'h00000013, 9'd8, '0, '0, 1'b1);
    send1(32'h402081B3, 9'd12, mk(9'd12, 1, 2, 3, 0, 0, 0, 0, 1, 0, 4'h1, 2'b00, 0));
    send1(32'h4020D1B3, 9'd16, mk(9'd16, 1, 2, 3, 0, 0, 0, 0, 1, 0, 4'hA, 2'b00, 0));
    send(32'h022081B3, 9'd20,
         mk(9'd20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 2'b00, 1),
         mk(9'd20, 1, 2, 3, 0, 0, 0, 0, 1, 0, 4'h0, 2'b11, 0), 1'b0);
    send1(32'hFE208EE3, 9'd24, mk(9'd24, 1, 2, 0, 0, 1, 0, 0, 0, 32'hFFFFFFFC, 4'h0, 2'b01, 0));
    send1(32'h00812283, 9'd28, mk(9'd28, 2, 0, 5, 1, 0, 1, 0, 1, 32'd8, 4'h2, 2'b10, 0));
    send1(32'h00512623, 9'd32, mk(9'd32, 2, 5, 0, 1, 0, 0, 1, 0, 32'd12, 4'h2, 2'b10, 0));
    send1(32'h123453B7, 9'd36, mk(9'd36, 0, 0, 7, 1, 0, 0, 0, 1, 32'h12345000, 4'h8, 2'b00, 0));
    send1(32'hFF9FF0EF, 9'd40, mk(9'd40, 0, 0, 1, 1, 1, 0, 0, 1, 32'hFFFFFFF8, 4'h0, 2'b01, 0));
    send1(32'h0030B283, 9'd44, mk(9'd44, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 2'b00, 1));
    send1(32'h40325213, 9'd48, mk(9'd48, 4, 0, 4, 1, 0, 0, 0, 1, 32'h403, 4'hA, 2'b00, 0));
    drain_check("decode_drain");

    // Backpressure: fill, hold head, then drain with o_ready timing
    i_ready = 1'b0;
    send1(32'h002081B3, 9'h20, mk(9'h20, 1, 2, 3, 0, 0, 0, 0, 1, 0, 4'h0, 2'b00, 0));
    send1(32'h402081B3, 9'h24, mk(9'h24, 1, 2, 3, 0, 0, 0, 0, 1, 0, 4'h1, 2'b00, 0));
    instruction = 32'h4020D1B3; i_pc = 9'h28; i_valid = 1'b1;
    e = mk(9'h28, 1, 2, 3, 0, 0, 0, 0, 1, 0, 4'hA, 2'b00, 0);
    q0.push_back(e); q1.push_back(e);
    chk("full_ready", o_ready_a[0], 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("full_hold_ready", o_ready_a[0], 0);
      chk("head_stable_pc", o_pc_a[0], 9'h20);
      chk("head_stable_aluop", aluop_a[0], 4'h0);
    end
    i_ready = 1'b1;
    chk("ready_before_deq", o_ready_a[0], 0);
    @(negedge clk);
    chk("ready_reassert", o_ready_a[0], 1);
    @(negedge clk);
    i_valid = 1'b0;
    drain_check("bp_drain");

    // Flush with full FIFO and a pending input
    i_ready = 1'b0;
    send1(32'h002081B3, 9'h30, mk(9'h30, 1, 2, 3, 0, 0, 0, 0, 1, 0, 4'h0, 2'b00, 0));
    send1(32'h402081B3, 9'h34, mk(9'h34, 1, 2, 3, 0, 0, 0, 0, 1, 0, 4'h1, 2'b00, 0));
    instruction = 32'h4020D1B3; i_pc = 9'h38; i_valid = 1'b1; flush = 1'b1;
    q0.delete(); q1.delete();
    @(negedge clk);
    flush = 1'b0; i_valid = 1'b0;
    chk("flush_full_valid", o_valid_a[0], 0);
    chk("flush_full_ready", o_ready_a[0], 1);
    i_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Flush while an input is actually accepted
    i_ready = 1'b0;
    send1(32'h002081B3, 9'h40, mk(9'h40, 1, 2, 3, 0, 0, 0, 0, 1, 0, 4'h0, 2'b00, 0));
    instruction = 32'h402081B3; i_pc = 9'h44; i_valid = 1'b1; flush = 1'b1;
    q0.delete(); q1.delete();
    @(negedge clk);
    flush = 1'b0; i_valid = 1'b0;
    chk("flush_in_valid", o_valid_a[1], 0);
    i_ready = 1'b1;
    repeat (3) @(negedge clk);
    send1(32'h123453B7, 9'h48, mk(9'h48, 0, 0, 7, 1, 0, 0, 0, 1, 32'h12345000, 4'h8, 2'b00, 0));
    drain_check("flush_drain");

    // Reset mid-operation clears state and outputs
    i_ready = 1'b0;
    send1(32'hFE208EE3, 9'h50, mk(9'h50, 1, 2, 0, 0, 1, 0, 0, 0, 32'hFFFFFFFC, 4'h0, 2'b01, 0));
    reset = 1'b1;
    q0.delete(); q1.delete();
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_valid", o_valid_a[0], 0);
    chk("midrst_ready", o_ready_a[0], 1);
    chk("midrst_outputs", act(0), '0);
    i_ready = 1'b1;
    drain_check("final_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
